// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a tx_en/tx_busy level handshake.
// Optional sticky overflow flag enabled by defining UART_TXF_OVERFLOW_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [7:0]    tx_data,
    output logic          tx_en,
    input  logic          tx_busy,
    input  logic          ovf_clr,
    output logic          overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_s;
    logic          full_r;
    logic          empty_r;
    logic [7:0]    tx_data_r;
    logic [7:0]    tx_data_s;
    logic          tx_en_r;
    logic          tx_en_s;
    logic          overflow_r;
    logic          overflow_s;
    logic          push_s;
    logic          pop_s;
    state_t        state_r;
    state_t        state_s;

    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign tx_data  = tx_data_r;
    assign tx_en    = tx_en_r;
    assign overflow = overflow_r;

    // A write is accepted only against the pre-edge fill level, even if a pop coincides.
    assign push_s = wr_en & ~full_r;

    // Drain FSM next-state and launch outputs; the pop happens only on IDLE->LAUNCH.
    always_comb begin
        state_s   = state_r;
        tx_en_s   = tx_en_r;
        tx_data_s = tx_data_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_r && !tx_busy) begin
                    pop_s     = 1'b1;
                    tx_data_s = mem_r[rd_ptr_r];
                    tx_en_s   = 1'b1;
                    state_s   = LAUNCH;
                end else begin
                    tx_en_s = 1'b0;
                    state_s = IDLE;
                end
            end
            LAUNCH: begin
                if (tx_busy) begin
                    tx_en_s = 1'b0;
                    state_s = WAIT_DONE;
                end else begin
                    tx_en_s = 1'b1;
                    state_s = LAUNCH;
                end
            end
            WAIT_DONE: begin
                tx_en_s = 1'b0;
                if (!tx_busy) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                tx_en_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Fill level after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + (AW+1)'(1);
            2'b01:   count_s = count_r - (AW+1)'(1);
            default: count_s = count_r;
        endcase
    end

`ifdef UART_TXF_OVERFLOW_EN
    // Sticky overflow: a dropped write wins over a same-cycle clear.
    always_comb begin
        overflow_s = overflow_r;
        if (wr_en && full_r) begin
            overflow_s = 1'b1;
        end else if (ovf_clr) begin
            overflow_s = 1'b0;
        end else begin
            overflow_s = overflow_r;
        end
    end
`else
    logic unused_ovf_clr_s;
    assign unused_ovf_clr_s = ovf_clr;

    // Overflow reporting compiled out.
    always_comb begin
        overflow_s = 1'b0;
    end
`endif

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, flags, FSM and registered transmitter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            tx_data_r  <= 8'h00;
            tx_en_r    <= 1'b0;
            overflow_r <= 1'b0;
            state_r    <= IDLE;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_s;
            full_r     <= (count_s == FULL_COUNT);
            empty_r    <= (count_s == '0);
            tx_data_r  <= tx_data_s;
            tx_en_r    <= tx_en_s;
            overflow_r <= overflow_s;
            state_r    <= state_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, launched bytes are popped and compared.
module tb_uart_tx_fifo;

`ifdef UART_TXF_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_busy;
    logic       ovf_clr;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_busy  (tx_busy),
        .ovf_clr  (ovf_clr),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input bit expect_accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (expect_accept) exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    // Second half of a frame: transmitter takes 3 cycles to raise busy, then finishes.
    task automatic finish_frame();
        logic [7:0] held;
        held = tx_data;
        repeat (3) tick();
        check("tx_data_stable", tx_data, held);
        check("tx_en_hold", tx_en, 1'b1);
        tx_busy = 1'b1;
        tick();
        check("tx_en_drop", tx_en, 1'b0);
        tick();
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic compare_launch();
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_frame", tx_data, 8'h00);
            n_fail++;
            $display("FAIL frame_without_expectation: got %0h expected none", tx_data);
        end else begin
            e = exp_q.pop_front();
            check("frame_order", tx_data, e);
        end
    endtask

    task automatic xmit_frame();
        int n = 0;
        while (!tx_en && n < 200) begin
            tick();
            n++;
        end
        if (!tx_en) begin
            check("launch_timeout", tx_en, 1'b1);
        end else begin
            compare_launch();
            finish_frame();
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0; ovf_clr = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_tx_en", tx_en, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_count", count, 5'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // First-byte latency and handshake
        write_byte(8'hA5, 1'b0);
        check("wr_count", count, 5'd1);
        check("wr_empty", empty, 1'b0);
        check("latency_not_yet", tx_en, 1'b0);
        tick();
        check("latency_tx_en", tx_en, 1'b1);
        check("latency_tx_data", tx_data, 8'hA5);
        tx_busy = 1'b1;
        tick();
        check("busy_drop_en", tx_en, 1'b0);
        tx_busy = 1'b0;
        tick();
        check("done_empty", empty, 1'b1);
        tick();
        check("idle_no_launch", tx_en, 1'b0);

        // Fill to full, overflow, then drain in order
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
        check("fill_full", full, 1'b1);
        check("fill_count", count, 5'd16);
        write_byte(8'hFF, 1'b0);
        check("ovf_count", count, 5'd16);
        check("ovf_flag", overflow, OVF_EN);
        tx_busy = 1'b0;
        repeat (16) xmit_frame();
        check("drain_empty", empty, 1'b1);
        check("drain_queue", exp_q.size(), 0);

        // Pointer wrap with concurrent producer and model transmitter
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int w = 0;
                    while (full && w < 500) begin
                        tick();
                        w++;
                    end
                    write_byte(8'((i * 7) + 3), 1'b1);
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                repeat (40) xmit_frame();
            end
        join
        check("wrap_queue", exp_q.size(), 0);
        check("wrap_empty", empty, 1'b1);

        // Same-cycle push and pop at count 5
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i), 1'b1);
        check("pp_pre_count", count, 5'd5);
        tx_busy = 1'b0;
        write_byte(8'h55, 1'b1);
        check("pp_count", count, 5'd5);
        check("pp_launch", tx_en, 1'b1);
        compare_launch();
        finish_frame();
        repeat (5) xmit_frame();
        check("pp_empty", empty, 1'b1);

        // Reset while in LAUNCH with four bytes queued
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i), 1'b0);
        tx_busy = 1'b0;
        tick();
        check("rl_launch", tx_en, 1'b1);
        check("rl_count", count, 5'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rl_tx_en", tx_en, 1'b0);
        check("rl_count0", count, 5'd0);
        check("rl_empty", empty, 1'b1);
        check("rl_tx_data", tx_data, 8'h00);
        tick();
        check("rl_stay_idle", tx_en, 1'b0);

        // Overflow clear, clear-vs-set priority, write-while-full-and-pop dropped
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0);
        write_byte(8'hEE, 1'b0);
        check("ovf_set", overflow, OVF_EN);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 1'b0);
        ovf_clr = 1'b1;
        write_byte(8'hEF, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_set_wins", overflow, OVF_EN);
        tx_busy = 1'b0;
        write_byte(8'hDD, 1'b0);
        check("full_pop_drop_count", count, 5'd15);
        check("full_pop_launch_data", tx_data, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
